aes128_encr_round_ctrl: RTL

//  Iterative round sequencer for the AES-128 encryption datapath. Takes one plaintext

---
 rtl/aes128_encr_round_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/aes128_encr_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes128_encr_round_ctrl
//  Description : Iterative AES-128 encryption round sequencer. Performs the
//                initial AddRoundKey on the accepted plaintext, then issues NR
//                passes through a shared registered round stage, indexing the
//                round key for each pass and flagging the final
//                (no-MixColumns) pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_encr_round_ctrl #(
  parameter int NR        = 10,
  parameter int STAGE_LAT = 1,
  parameter int KIDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [127:0]      i_plaintext,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [127:0]      o_ciphertext,
  output logic [KIDX_W-1:0] o_key_idx,
  input  logic [127:0]      i_key_in,
  output logic              o_rnd_valid,
  output logic              o_rnd_last,
  output logic [127:0]      o_rnd_data_out,
  output logic [127:0]      o_rnd_key_out,
  input  logic [127:0]      i_rnd_data_in
);

  localparam int RND_W  = $clog2(NR + 1);
  localparam int WCNT_W = $clog2(STAGE_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RND_W-1:0]    r_round;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [127:0]        r_state_reg;
  logic [127:0]        r_ciphertext;
  logic                r_done;

  logic                w_accept;
  logic                w_capture;
  logic                w_abort_busy;
  logic                w_round_is_last;
  logic                w_wait_last;

  assign w_round_is_last = (r_round == RND_W'(NR));
  assign w_wait_last     = (r_wcnt == WCNT_W'(1));

  // Next-state decode plus the strobes that steer the datapath registers.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_abort_busy = 1'b0;
    case (r_state)
      S_IDLE: begin
        // abort has priority over a simultaneous start request
        if (i_start && !i_abort) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_abort) begin
          w_abort_busy = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_abort) begin
          w_abort_busy = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (w_wait_last) begin
          w_capture   = 1'b1;
          w_state_nxt = w_round_is_last ? S_IDLE : S_ISSUE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Round counter, stage wait counter, cipher state and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round      <= '0;
      r_wcnt       <= '0;
      r_state_reg  <= '0;
      r_ciphertext <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        // initial AddRoundKey uses round key 0 (key_idx is 0 in IDLE)
        r_state_reg <= i_plaintext ^ i_key_in;
        r_round     <= RND_W'(1);
      end

      if (r_state == S_ISSUE) begin
        r_wcnt <= WCNT_W'(STAGE_LAT);
      end else if (r_state == S_WAIT && !w_wait_last) begin
        r_wcnt <= r_wcnt - WCNT_W'(1);
      end

      if (w_capture) begin
        if (w_round_is_last) begin
          r_ciphertext <= i_rnd_data_in;
          r_done       <= 1'b1;
          r_round      <= '0;
        end else begin
          r_state_reg <= i_rnd_data_in;
          r_round     <= r_round + RND_W'(1);
        end
      end

      if (w_abort_busy) begin
        r_round <= '0;
      end
    end
  end

  assign o_ready        = (r_state == S_IDLE);
  assign o_busy         = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign o_done         = r_done;
  assign o_ciphertext   = r_ciphertext;
  // key index stays on the current round through WAIT: the stage applies its
  // AddRoundKey after its output register, so the key must be stable to capture
  assign o_key_idx      = (r_state == S_IDLE) ? '0 : KIDX_W'(r_round);
  assign o_rnd_valid    = (r_state == S_ISSUE);
  assign o_rnd_last     = o_busy && w_round_is_last;
  assign o_rnd_data_out = r_state_reg;
  assign o_rnd_key_out  = i_key_in;

endmodule
`default_nettype wire
